// File: rtl/number_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, blank code on overflow.
// Optional BCD_AUTO_START_EN: self-start whenever Number differs from the last captured value.
module number_bcd_converter #(
  parameter int IN_WIDTH   = 32,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [IN_WIDTH-1:0]     Number,
  input  logic                    Start,
  output logic [4*NUM_DIGITS-1:0] Digits,
  output logic                    Overflow,
  output logic                    Busy,
  output logic                    Done
);
  localparam int AW = 4*NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH-1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] sr_q, sr_d;
  logic [AW-1:0]       acc_q, acc_d, acc_adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [AW-1:0]       digits_q, digits_d;
  logic                ovfo_q, ovfo_d;
  logic                done_q, done_d;
  logic                too_big, start_req;

  assign too_big = 64'(Number) >= LIMIT;

  // No acceptance during the Done cycle, so back-to-back runs space out by one idle edge.
`ifdef BCD_AUTO_START_EN
  logic [IN_WIDTH-1:0] last_q, last_d;
  assign start_req = (Start | (Number != last_q)) & ~done_q;
`else
  assign start_req = Start & ~done_q;
`endif

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    ovfo_d   = ovfo_q;
    done_d   = 1'b0;
`ifdef BCD_AUTO_START_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_req) begin
          sr_d  = Number;
          acc_d = '0;
          cnt_d = '0;
`ifdef BCD_AUTO_START_EN
          last_d = Number;
`endif
          if (too_big) begin
            acc_d   = '1;
            ovf_d   = 1'b1;
            state_d = FINISH;
          end else begin
            ovf_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = {acc_adj[AW-2:0], sr_q[IN_WIDTH-1]};
        sr_d  = {sr_q[IN_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FINISH;
      end
      FINISH: begin
        // Overflow arrives with a zero count: spend one extra cycle here before publishing.
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else begin
          digits_d = acc_q;
          ovfo_d   = ovf_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      digits_q <= '1;
      ovfo_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BCD_AUTO_START_EN
      last_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
      ovfo_q   <= ovfo_d;
      done_q   <= done_d;
`ifdef BCD_AUTO_START_EN
      last_q   <= last_d;
`endif
    end
  end

  assign Digits   = digits_q;
  assign Overflow = ovfo_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
endmodule

// File: tb/tb_number_bcd_converter.sv
// Directed bench for number_bcd_converter with a result scoreboard checked on every Done pulse.
module tb_number_bcd_converter;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] Number = '0;
  logic        Start = 1'b0;
  logic [15:0] Digits;
  logic        Overflow, Busy, Done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {logic [15:0] d; logic o;} exp_t;
  exp_t sb[$];

  number_bcd_converter dut (
    .Clk(Clk), .Rst_n(Rst_n), .Number(Number), .Start(Start),
    .Digits(Digits), .Overflow(Overflow), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] n);
    exp_t e;
    logic [31:0] v;
    v = n;
    if (n >= 32'd10000) begin
      e.d = 16'hFFFF; e.o = 1'b1;
    end else begin
      e.o = 1'b0;
      for (int i = 0; i < 4; i++) begin
        e.d[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return e;
  endfunction

  always @(negedge Clk) begin
    if (Rst_n && Done) begin
      exp_t e;
      done_cnt++;
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("digits", 64'(Digits), 64'(e.d));
        chk("overflow", 64'(Overflow), 64'(e.o));
      end
    end
  end

  task automatic run(input logic [31:0] n, input int lat, input int chg_at, input logic [31:0] chg_n);
    int t0, nb;
    bit got;
    Number = n;
    Start = 1'b1;
    sb.push_back(model(n));
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    t0 = cyc;
    nb = 0;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      if (Done) begin got = 1; break; end
      if (Busy) nb++;
      if (chg_at > 0 && cyc - t0 == chg_at) Number = chg_n;
      @(negedge Clk);
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(cyc - t0), 64'(lat));
    chk("busy_cycles", 64'(nb), 64'(lat));
    chk("busy_low_at_done", 64'(Busy), 64'd0);
    @(negedge Clk);
    chk("done_one_cycle", 64'(Done), 64'd0);
  endtask

  initial begin
    int t0, n, dn;
    int dt[3];
    bit prevd;
    repeat (3) @(negedge Clk);
    chk("rst_digits", 64'(Digits), 64'hFFFF);
    chk("rst_overflow", 64'(Overflow), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
`ifdef BCD_AUTO_START_EN
    repeat (40) @(negedge Clk);
    chk("auto_idle_zero", 64'(done_cnt), 64'd0);
    Number = 32'd7;
    sb.push_back(model(32'd7));
    for (int k = 0; k < 60 && done_cnt < 1; k++) @(negedge Clk);
    repeat (50) @(negedge Clk);
    Number = 32'd7;
    repeat (10) @(negedge Clk);
    Number = 32'd256;
    sb.push_back(model(32'd256));
    for (int k = 0; k < 60 && done_cnt < 2; k++) @(negedge Clk);
    repeat (50) @(negedge Clk);
    chk("auto_conversions", 64'(done_cnt), 64'd2);
`else
    run(32'd1234, 33, 0, 0);
    run(32'd0, 33, 0, 0);
    run(32'd9999, 33, 0, 0);
    run(32'd10000, 2, 0, 0);
    run(32'hFFFF_FFFF, 2, 0, 0);
    run(32'd1234, 33, 5, 32'd5678);
    run(32'd5678, 33, 0, 0);

    // Start held high: exactly one conversion per 35 cycles, each Done one cycle wide.
    Number = 32'd42;
    Start = 1'b1;
    repeat (3) sb.push_back(model(32'd42));
    @(posedge Clk);
    @(negedge Clk);
    t0 = cyc;
    n = 0;
    prevd = 0;
    for (int k = 0; k < 150 && n < 3; k++) begin
      if (Done) begin
        chk("held_done_width", 64'(prevd), 64'd0);
        dt[n] = cyc;
        n++;
        if (n == 3) Start = 1'b0;
      end
      prevd = Done;
      @(negedge Clk);
    end
    chk("held_count", 64'(n), 64'd3);
    chk("held_first", 64'(dt[0] - t0), 64'd33);
    chk("held_period1", 64'(dt[1] - dt[0]), 64'd35);
    chk("held_period2", 64'(dt[2] - dt[1]), 64'd35);
    repeat (40) @(negedge Clk);
    chk("held_not_queued", 64'(sb.size()), 64'd0);

    // Reset mid-conversion.
    Number = 32'd1234;
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 20 && cyc - t0 < 10; k++) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("abort_digits", 64'(Digits), 64'hFFFF);
    chk("abort_overflow", 64'(Overflow), 64'd0);
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    dn = done_cnt;
    repeat (50) @(negedge Clk);
    chk("abort_no_done", 64'(done_cnt - dn), 64'd0);
    run(32'd7, 33, 0, 0);
`endif
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
